// File: rtl/pwm_bank_if.sv
// pwm_bank_if: byte-wide register port between the SPI peripheral (master) and pwm_bank (slave).
//   wr_en    - write strobe, one cycle per write
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - combinational readback of the register at rd_addr
interface pwm_bank_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: parametrised multi-channel PWM generator.
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   bus          - register port (pwm_bank_if.slave)
//   out          - registered channel outputs, NUM_CH wide
//   period_start - one-cycle pulse when the period counter wraps to 0
// Register map: 0x00..0x03 OUT_EN, 0x04..0x07 PWM_EN, 0x08 PRESC, 0x09 TOP, 0x10+i DUTY[i].
// Optional feature macro: PWM_SHADOW_EN - DUTY writes land in a shadow register that is
// copied to the active duty when the period counter wraps.
module pwm_bank #(
  parameter int unsigned NUM_CH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_bank_if.slave         bus,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  logic [NUM_CH-1:0] out_en;
  logic [NUM_CH-1:0] pwm_en;
  logic [7:0]        presc;
  logic [7:0]        top;
  logic [7:0]        pc;
  logic [7:0]        cnt;
  logic [7:0]        duty_wr  [NUM_CH];
  logic [7:0]        duty_act [NUM_CH];
  logic              tick;
  logic              wrap;
  logic [31:0]       out_en_ext;
  logic [31:0]       pwm_en_ext;

  // >= rather than == so lowering PRESC/TOP below the live count wraps at once.
  assign tick = (pc >= presc);
  assign wrap = tick && (cnt >= top);

  // Register file; writes to bits of absent channels simply have no storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en <= '0;
      pwm_en <= '0;
      presc  <= 8'h00;
      top    <= 8'hfe;
      for (int i = 0; i < int'(NUM_CH); i++) duty_wr[i] <= 8'h00;
    end else if (bus.wr_en) begin
      if (bus.wr_addr == 8'h08) presc <= bus.wr_data;
      if (bus.wr_addr == 8'h09) top <= bus.wr_data;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (bus.wr_addr == 8'(i / 8))      out_en[i]  <= bus.wr_data[i % 8];
        if (bus.wr_addr == 8'(4 + i / 8))  pwm_en[i]  <= bus.wr_data[i % 8];
        if (bus.wr_addr == 8'(16 + i))     duty_wr[i] <= bus.wr_data;
      end
    end
  end

  // Prescaler and period counter; period_start is registered alongside cnt's return to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= 8'h00;
      cnt          <= 8'h00;
      period_start <= 1'b0;
    end else begin
      pc <= tick ? 8'h00 : pc + 8'd1;
      if (tick) cnt <= (cnt >= top) ? 8'h00 : cnt + 8'd1;
      period_start <= wrap;
    end
  end

`ifdef PWM_SHADOW_EN
  // Active duty only changes at the wrap so no period mixes two duty values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) duty_act[i] <= 8'h00;
    end else if (wrap) begin
      for (int i = 0; i < int'(NUM_CH); i++) duty_act[i] <= duty_wr[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) duty_act[i] = duty_wr[i];
  end
`endif

  // Outputs lag cnt by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        out[i] <= out_en[i] & (~pwm_en[i] | (duty_act[i] > cnt));
      end
    end
  end

  // Zero-extended copies make absent enable bits and bytes read back as 0.
  assign out_en_ext = 32'(out_en);
  assign pwm_en_ext = 32'(pwm_en);

  always_comb begin
    bus.rd_data = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (bus.rd_addr == 8'(k))     bus.rd_data = out_en_ext[8*k +: 8];
      if (bus.rd_addr == 8'(4 + k)) bus.rd_data = pwm_en_ext[8*k +: 8];
    end
    if (bus.rd_addr == 8'h08) bus.rd_data = presc;
    if (bus.rd_addr == 8'h09) bus.rd_data = top;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (bus.rd_addr == 8'(16 + i)) bus.rd_data = duty_wr[i];
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
module tb_pwm_bank;
  logic        clk;
  logic        rst_n;
  logic [15:0] out;
  logic        period_start;
  logic [4:0]  out5;
  logic        period_start5;

  int vec_cnt = 0;
  int err_cnt = 0;

  pwm_bank_if bus ();
  pwm_bank_if bus5 ();

  pwm_bank #(.NUM_CH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .out          (out),
    .period_start (period_start)
  );

  pwm_bank #(.NUM_CH(5)) dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus5),
    .out          (out5),
    .period_start (period_start5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the write is sampled on the next posedge; returns at the negedge after.
  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.wr_en = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wr5(input logic [7:0] addr, input logic [7:0] data);
    bus5.wr_en = 1'b1;
    bus5.wr_addr = addr;
    bus5.wr_data = data;
    @(negedge clk);
    bus5.wr_en = 1'b0;
  endtask

  // Advance negedge by negedge until period_start is seen; an expired bound is a failure.
  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 2000);
    if (!period_start) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL wait_ps: period_start not seen within %0d cycles", n);
    end
  endtask

  // Skip one period, then measure one full period of out[0].
  task automatic measure(output int highs, output int plen);
    wait_ps();
    wait_ps();
    highs = 0;
    plen = 0;
    do begin
      @(negedge clk);
      plen++;
      if (out[0]) highs++;
    end while (!period_start && plen < 2000);
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    bit seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (out !== 16'h0 || period_start !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_out: got out=%h ps=%b expected 0000/0", out, period_start);
    end
    rst_n = 1'b1;
    for (int a = 0; a < 49; a++) begin
      bus.rd_addr = (a == 48) ? 8'hff : 8'(a);
      bus5.rd_addr = bus.rd_addr;
      exp = (bus.rd_addr == 8'h09) ? 8'hfe : 8'h00;
      #1;
      vec_cnt++;
      if (bus.rd_data !== exp || bus5.rd_data !== exp) begin
        err_cnt++;
        $display("FAIL reset_rd[%h]: got %h/%h expected %h", bus.rd_addr, bus.rd_data,
                 bus5.rd_data, exp);
      end
    end
    @(negedge clk);
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (period_start) seen = 1;
    end
    vec_cnt++;
    if (seen) begin
      err_cnt++;
      $display("FAIL reset_no_ps: got period_start=1 expected 0 in first period");
    end
  endtask

  task automatic test_static();
    @(negedge clk);
    wr(8'h00, 8'h01);
    vec_cnt++;
    if (out[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL static_latency: got %b expected 0", out[0]);
    end
    @(negedge clk);
    vec_cnt++;
    if (out !== 16'h0001) begin
      err_cnt++;
      $display("FAIL static_high: got %h expected 0001", out);
    end
    wr(8'h00, 8'h00);
    @(negedge clk);
    vec_cnt++;
    if (out !== 16'h0000) begin
      err_cnt++;
      $display("FAIL static_off: got %h expected 0000", out);
    end
  endtask

  task automatic test_duty_sweep();
    int highs, plen;
    logic [7:0] duty [3] = '{8'h80, 8'h00, 8'hff};
    int exp_h [3] = '{128, 0, 255};
    @(negedge clk);
    wr(8'h00, 8'h01);
    wr(8'h04, 8'h01);
    for (int k = 0; k < 3; k++) begin
      wr(8'h10, duty[k]);
      measure(highs, plen);
      vec_cnt++;
      if (plen !== 255 || highs !== exp_h[k]) begin
        err_cnt++;
        $display("FAIL duty_%h: got period=%0d high=%0d expected 255/%0d", duty[k], plen,
                 highs, exp_h[k]);
      end
    end
  endtask

  task automatic test_prescale();
    int highs, plen;
    @(negedge clk);
    wr(8'h08, 8'd3);
    wr(8'h09, 8'd9);
    wr(8'h10, 8'd5);
    measure(highs, plen);
    vec_cnt++;
    if (plen !== 40 || highs !== 20) begin
      err_cnt++;
      $display("FAIL prescale: got period=%0d high=%0d expected 40/20", plen, highs);
    end
  endtask

  task automatic test_boundary();
    int plen;
    @(negedge clk);
    wr(8'h08, 8'd0);
    wr(8'h09, 8'hfe);
    wait_ps();
    wait_ps();
    repeat (200) @(negedge clk);
    wr(8'h09, 8'h10);
    vec_cnt++;
    if (period_start !== 1'b0) begin
      err_cnt++;
      $display("FAIL top_shrink_early: got ps=%b expected 0", period_start);
    end
    @(negedge clk);
    vec_cnt++;
    if (period_start !== 1'b1) begin
      err_cnt++;
      $display("FAIL top_shrink_wrap: got ps=%b expected 1", period_start);
    end
    plen = 0;
    do begin
      @(negedge clk);
      plen++;
    end while (!period_start && plen < 100);
    vec_cnt++;
    if (plen !== 17) begin
      err_cnt++;
      $display("FAIL top_shrink_period: got %0d expected 17", plen);
    end
  endtask

  task automatic test_duty_update();
    logic exp_mid;
`ifdef PWM_SHADOW_EN
    exp_mid = 1'b0;
`else
    exp_mid = 1'b1;
`endif
    @(negedge clk);
    wr(8'h09, 8'd9);
    wr(8'h10, 8'd2);
    wait_ps();
    wait_ps();
    repeat (3) @(negedge clk);
    wr(8'h10, 8'd8);
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (out[0] !== exp_mid) begin
      err_cnt++;
      $display("FAIL duty_mid_period: got %b expected %b", out[0], exp_mid);
    end
    repeat (11) @(negedge clk);
    vec_cnt++;
    if (out[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL duty_next_high: got %b expected 1", out[0]);
    end
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (out[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL duty_next_low: got %b expected 0", out[0]);
    end
  endtask

  task automatic test_num_ch5();
    logic [7:0] addr [5] = '{8'h00, 8'h01, 8'h15, 8'h14, 8'h2f};
    logic [7:0] exp  [5] = '{8'h1f, 8'h00, 8'h00, 8'h33, 8'h00};
    @(negedge clk);
    wr5(8'h00, 8'hff);
    wr5(8'h01, 8'hff);
    wr5(8'h15, 8'haa);
    wr5(8'h14, 8'h33);
    wr5(8'h2f, 8'h77);
    for (int k = 0; k < 5; k++) begin
      bus5.rd_addr = addr[k];
      #1;
      vec_cnt++;
      if (bus5.rd_data !== exp[k]) begin
        err_cnt++;
        $display("FAIL ch5_rd[%h]: got %h expected %h", addr[k], bus5.rd_data, exp[k]);
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (out5 !== 5'h1f) begin
      err_cnt++;
      $display("FAIL ch5_out: got %h expected 1f", out5);
    end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    wr(8'h04, 8'h00);
    @(negedge clk);
    vec_cnt++;
    if (out[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_reset_out: got %b expected 1", out[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    bus.rd_addr = 8'h00;
    #1;
    vec_cnt++;
    if (out !== 16'h0 || bus.rd_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL async_reset: got out=%h rd0=%h expected 0000/00", out, bus.rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 400);
    vec_cnt++;
    if (n !== 255) begin
      err_cnt++;
      $display("FAIL first_period_after_reset: got ps at %0d expected 255", n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = 8'h00;
    bus.wr_data = 8'h00;
    bus.rd_addr = 8'h00;
    bus5.wr_en = 1'b0;
    bus5.wr_addr = 8'h00;
    bus5.wr_data = 8'h00;
    bus5.rd_addr = 8'h00;
    test_reset();
    test_static();
    test_duty_sweep();
    test_prescale();
    test_boundary();
    test_duty_update();
    test_num_ch5();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
